// File: rtl/de_ex_issue_pkg.sv
// Shared types and widths for the decode-to-execute issue stage.
// Operand width and register index width are fixed here.
package de_ex_issue_pkg;

  localparam int unsigned Xlen  = 32;
  localparam int unsigned RegAw = 5;

  localparam logic [RegAw-1:0] RegZero = '0;

  typedef struct packed {
    logic [Xlen-1:0]  s1;
    logic [Xlen-1:0]  s2;
    logic [Xlen-1:0]  uimm;
    logic [Xlen-1:0]  pc;
    logic             uimm_en;
    logic             add_op_en;
    logic             rd_en;
    logic [RegAw-1:0] rd_idx;
  } issue_op_t;

  typedef enum logic [1:0] {
    StEmpty,
    StFull,
    StSkid
  } issue_state_e;

  // A source participates in resolution only if enabled and not x0.
  function automatic logic src_live(input logic en, input logic [RegAw-1:0] idx);
    return en && (idx != RegZero);
  endfunction

endpackage

// File: rtl/de_ex_issue_if.sv
// Decode, execute and writeback signals seen by the issue stage.
// master: the issue stage itself; slave: the surrounding decode/execute/writeback logic.
interface de_ex_issue_if;
  import de_ex_issue_pkg::*;

  logic             de_valid;
  logic             de_ready;
  logic             de_rs1_en;
  logic             de_rs2_en;
  logic             de_rd_en;
  logic [RegAw-1:0] de_rs1_idx;
  logic [RegAw-1:0] de_rs2_idx;
  logic [RegAw-1:0] de_rd_idx;
  logic [Xlen-1:0]  de_rs1_data;
  logic [Xlen-1:0]  de_rs2_data;
  logic [Xlen-1:0]  de_uimm;
  logic [Xlen-1:0]  de_pc;
  logic             de_uimm_en;
  logic             de_add_op_en;

  logic             ex_valid;
  logic             ex_ready;
  logic [Xlen-1:0]  ex_s1;
  logic [Xlen-1:0]  ex_s2;
  logic [Xlen-1:0]  ex_uimm;
  logic [Xlen-1:0]  ex_pc;
  logic             ex_uimm_en;
  logic             ex_add_op_en;
  logic             ex_rd_en;
  logic [RegAw-1:0] ex_rd_idx;
  logic [Xlen-1:0]  ex_result;

  logic             wb_en;
  logic [RegAw-1:0] wb_idx;
  logic [Xlen-1:0]  wb_data;

  modport master (
    input  de_valid, de_rs1_en, de_rs2_en, de_rd_en, de_rs1_idx, de_rs2_idx, de_rd_idx,
           de_rs1_data, de_rs2_data, de_uimm, de_pc, de_uimm_en, de_add_op_en,
           ex_ready, ex_result, wb_en, wb_idx, wb_data,
    output de_ready, ex_valid, ex_s1, ex_s2, ex_uimm, ex_pc, ex_uimm_en, ex_add_op_en,
           ex_rd_en, ex_rd_idx
  );

  modport slave (
    output de_valid, de_rs1_en, de_rs2_en, de_rd_en, de_rs1_idx, de_rs2_idx, de_rd_idx,
           de_rs1_data, de_rs2_data, de_uimm, de_pc, de_uimm_en, de_add_op_en,
           ex_ready, ex_result, wb_en, wb_idx, wb_data,
    input  de_ready, ex_valid, ex_s1, ex_s2, ex_uimm, ex_pc, ex_uimm_en, ex_add_op_en,
           ex_rd_en, ex_rd_idx
  );

endinterface

// File: rtl/de_ex_fwd_mux.sv
// Single-source operand resolution: x0/disabled, then execute result, then writeback, then RF.
// Only built when DE_EX_ISSUE_BYPASS_EN is defined.
`ifdef DE_EX_ISSUE_BYPASS_EN
module de_ex_fwd_mux
  import de_ex_issue_pkg::*;
(
  input  logic             src_en,
  input  logic [RegAw-1:0] src_idx,
  input  logic [Xlen-1:0]  rf_data,
  input  logic             ex_hit_en,
  input  logic [RegAw-1:0] ex_rd_idx,
  input  logic [Xlen-1:0]  ex_result,
  input  logic             wb_en,
  input  logic [RegAw-1:0] wb_idx,
  input  logic [Xlen-1:0]  wb_data,
  output logic [Xlen-1:0]  src_data
);

  always_comb begin
    src_data = rf_data;
    if (!src_live(src_en, src_idx)) begin
      src_data = '0;
    end else if (ex_hit_en && (ex_rd_idx == src_idx)) begin
      src_data = ex_result;
    end else if (wb_en && (wb_idx == src_idx)) begin
      src_data = wb_data;
    end
  end

endmodule
`endif

// File: rtl/de_ex_issue.sv
// Decode-to-execute issue stage: 2-entry skid buffer with operand capture at accept time.
// DE_EX_ISSUE_BYPASS_EN selects forwarding; otherwise dependent ops stall in decode.
module de_ex_issue
  import de_ex_issue_pkg::*;
(
  input logic           clk,
  input logic           rst,
  de_ex_issue_if.master bus
);

  issue_state_e    state_q;
  issue_op_t       out_q;
  issue_op_t       skid_q;
  issue_op_t       new_op;
  logic            ready_q;
  logic            de_ready;
  logic            ex_valid;
  logic            accept;
  logic            fire;
  logic [Xlen-1:0] rs1_val;
  logic [Xlen-1:0] rs2_val;

  assign ex_valid = (state_q != StEmpty);

`ifdef DE_EX_ISSUE_BYPASS_EN
  logic ex_hit_en;
  assign ex_hit_en = ex_valid && out_q.rd_en;

  de_ex_fwd_mux u_fwd_rs1 (
    .src_en    (bus.de_rs1_en),
    .src_idx   (bus.de_rs1_idx),
    .rf_data   (bus.de_rs1_data),
    .ex_hit_en (ex_hit_en),
    .ex_rd_idx (out_q.rd_idx),
    .ex_result (bus.ex_result),
    .wb_en     (bus.wb_en),
    .wb_idx    (bus.wb_idx),
    .wb_data   (bus.wb_data),
    .src_data  (rs1_val)
  );

  de_ex_fwd_mux u_fwd_rs2 (
    .src_en    (bus.de_rs2_en),
    .src_idx   (bus.de_rs2_idx),
    .rf_data   (bus.de_rs2_data),
    .ex_hit_en (ex_hit_en),
    .ex_rd_idx (out_q.rd_idx),
    .ex_result (bus.ex_result),
    .wb_en     (bus.wb_en),
    .wb_idx    (bus.wb_idx),
    .wb_data   (bus.wb_data),
    .src_data  (rs2_val)
  );

  assign de_ready = ready_q;
`else
  logic stall;
  logic unused_fwd;

  function automatic logic rd_hit(input logic valid, input issue_op_t op,
                                  input logic [RegAw-1:0] idx);
    return valid && op.rd_en && (op.rd_idx == idx);
  endfunction

  function automatic logic src_hazard(input logic en, input logic [RegAw-1:0] idx,
                                      input logic out_v, input issue_op_t out_op,
                                      input logic skid_v, input issue_op_t skid_op,
                                      input logic wb_en, input logic [RegAw-1:0] wb_idx);
    return src_live(en, idx) &&
           (rd_hit(out_v, out_op, idx) || rd_hit(skid_v, skid_op, idx) ||
            (wb_en && (wb_idx == idx)));
  endfunction

  // Without forwarding, a pending producer anywhere downstream blocks the consumer.
  always_comb begin
    stall = src_hazard(bus.de_rs1_en, bus.de_rs1_idx, ex_valid, out_q,
                       state_q == StSkid, skid_q, bus.wb_en, bus.wb_idx) ||
            src_hazard(bus.de_rs2_en, bus.de_rs2_idx, ex_valid, out_q,
                       state_q == StSkid, skid_q, bus.wb_en, bus.wb_idx);
  end

  assign rs1_val    = src_live(bus.de_rs1_en, bus.de_rs1_idx) ? bus.de_rs1_data : '0;
  assign rs2_val    = src_live(bus.de_rs2_en, bus.de_rs2_idx) ? bus.de_rs2_data : '0;
  assign de_ready   = ready_q && !stall;
  assign unused_fwd = ^{bus.ex_result, bus.wb_data};
`endif

  assign accept = bus.de_valid && de_ready;
  assign fire   = ex_valid && bus.ex_ready;

  // Execute ORs uimm into S1 and pc into S2, so the unused slot of each pair must be zero.
  always_comb begin
    new_op           = '0;
    new_op.s1        = bus.de_uimm_en   ? '0 : rs1_val;
    new_op.s2        = bus.de_add_op_en ? '0 : rs2_val;
    new_op.uimm      = bus.de_uimm_en   ? bus.de_uimm : '0;
    new_op.pc        = bus.de_add_op_en ? bus.de_pc   : '0;
    new_op.uimm_en   = bus.de_uimm_en;
    new_op.add_op_en = bus.de_add_op_en;
    new_op.rd_en     = bus.de_rd_en;
    new_op.rd_idx    = bus.de_rd_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      ready_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            out_q   <= new_op;
            state_q <= StFull;
          end
        end
        StFull: begin
          if (accept && fire) begin
            out_q <= new_op;
          end else if (accept) begin
            skid_q  <= new_op;
            state_q <= StSkid;
            ready_q <= 1'b0;
          end else if (fire) begin
            state_q <= StEmpty;
          end
        end
        StSkid: begin
          if (fire) begin
            out_q   <= skid_q;
            state_q <= StFull;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end
  end

  assign bus.de_ready     = de_ready;
  assign bus.ex_valid     = ex_valid;
  assign bus.ex_s1        = out_q.s1;
  assign bus.ex_s2        = out_q.s2;
  assign bus.ex_uimm      = out_q.uimm;
  assign bus.ex_pc        = out_q.pc;
  assign bus.ex_uimm_en   = out_q.uimm_en;
  assign bus.ex_add_op_en = out_q.add_op_en;
  assign bus.ex_rd_en     = out_q.rd_en;
  assign bus.ex_rd_idx    = out_q.rd_idx;

endmodule
